// File: rtl/mips_multicycle_ctrl_if.sv
// Control-unit bus: IR fields and ALU flag in, datapath selects/enables out.
// master = control unit, slave = datapath/IR side.
interface mips_multicycle_ctrl_if #(
  parameter int ALU_CTRL_W = 3
);
  logic [5:0]            op;
  logic [5:0]            Funct;
  logic                  Zero;
  logic                  PC_en;
  logic                  Mem_write;
  logic                  lorD_mux;
  logic                  IR_write;
  logic                  Reg_Dst_mux;
  logic                  Mem_reg_mux;
  logic                  Reg_write;
  logic                  ALU_srcA_mux;
  logic [1:0]            ALU_srcB_mux;
  logic [ALU_CTRL_W-1:0] ALU_control;
  logic [1:0]            Pc_src_mux;
  logic                  Imm_zext;
  logic [3:0]            state_o;
  logic                  illegal_op;

  modport master (
    input  op, Funct, Zero,
    output PC_en, Mem_write, lorD_mux, IR_write, Reg_Dst_mux, Mem_reg_mux,
           Reg_write, ALU_srcA_mux, ALU_srcB_mux, ALU_control, Pc_src_mux,
           Imm_zext, state_o, illegal_op
  );

  modport slave (
    output op, Funct, Zero,
    input  PC_en, Mem_write, lorD_mux, IR_write, Reg_Dst_mux, Mem_reg_mux,
           Reg_write, ALU_srcA_mux, ALU_srcB_mux, ALU_control, Pc_src_mux,
           Imm_zext, state_o, illegal_op
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: shared-state Moore FSM with memory wait states.
// Define ILLOP_TRAP_EN to trap illegal instructions in HALT; otherwise they act as NOPs.
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT   = 0,
  parameter int ALU_CTRL_W = 3
) (
  input logic                  clock,
  input logic                  rst,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       bne;
    logic       mem_write;
    logic       lord;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_reg;
    logic       reg_write;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic       imm_zext;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW  = 6'b101011,
                         OP_ADDI  = 6'b001000, OP_ORI = 6'b001101, OP_BEQ = 6'b000100,
                         OP_BNE   = 6'b000101, OP_J   = 6'b000010;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                         ALU_OR  = 3'b001, ALU_SLT = 3'b111;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
           (fn == 6'b100101) || (fn == 6'b101010);
  endfunction

  function automatic logic [2:0] alu_from_funct(input logic [5:0] fn);
    case (fn)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  // Control word for a state; 'last' marks the final cycle of a memory state.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic last,
                                        input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.ir_write = last; c.pc_write = last; c.srcb = 2'b01; c.alu = ALU_ADD; end
      S_DECODE: begin c.srcb = 2'b11; c.alu = ALU_ADD; end
      S_MEMADR: begin c.srca = 1'b1; c.srcb = 2'b10; c.alu = ALU_ADD; end
      S_MEMRD:  c.lord = 1'b1;
      S_MEMWB:  begin c.mem_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWR:  begin c.lord = 1'b1; c.mem_write = last; end
      S_EXEC:   begin c.srca = 1'b1; c.srcb = 2'b00; c.alu = alu_from_funct(fn); end
      S_ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_IEXEC: begin
        c.srca     = 1'b1;
        c.srcb     = 2'b10;
        c.alu      = (op == OP_ORI) ? ALU_OR : ALU_ADD;
        c.imm_zext = (op == OP_ORI);
      end
      S_IWB:    c.reg_write = 1'b1;
      S_BRANCH: begin
        c.srca = 1'b1; c.srcb = 2'b00; c.alu = ALU_SUB; c.pc_src = 2'b01;
        c.branch = 1'b1; c.bne = (op == OP_BNE);
      end
      S_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      S_HALT:   c.illegal = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  ctrl_t      ctrl_q;

  // Next state; memory states hold until the wait counter reaches MEM_WAIT.
  always_comb begin
    state_d = state_q;
    wait_d  = 4'd0;
    case (state_q)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (wait_q != WAIT_LAST) begin
          wait_d = wait_q + 4'd1;
        end else begin
          case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_MEMRD: state_d = S_MEMWB;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_ADDI, OP_ORI:  state_d = S_IEXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default:          state_d = S_FETCH;
        endcase
        if (bus.op == OP_RTYPE && funct_legal(bus.Funct)) state_d = S_EXEC;
`ifdef ILLOP_TRAP_EN
        if (state_d == S_FETCH) state_d = S_HALT;
`endif
      end
      S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
`ifdef ILLOP_TRAP_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= 4'd0;
      ctrl_q  <= decode_ctrl(S_FETCH, WAIT_LAST == 4'd0, bus.op, bus.Funct);
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ctrl_q  <= decode_ctrl(state_d, wait_d == WAIT_LAST, bus.op, bus.Funct);
    end
  end

  // Enables are gated by reset so nothing writes while rst is held low.
  assign bus.PC_en        = rst & (ctrl_q.pc_write |
                                   (ctrl_q.branch & (ctrl_q.bne ? ~bus.Zero : bus.Zero)));
  assign bus.Mem_write    = rst & ctrl_q.mem_write;
  assign bus.IR_write     = rst & ctrl_q.ir_write;
  assign bus.Reg_write    = rst & ctrl_q.reg_write;
  assign bus.lorD_mux     = ctrl_q.lord;
  assign bus.Reg_Dst_mux  = ctrl_q.reg_dst;
  assign bus.Mem_reg_mux  = ctrl_q.mem_reg;
  assign bus.ALU_srcA_mux = ctrl_q.srca;
  assign bus.ALU_srcB_mux = ctrl_q.srcb;
  assign bus.ALU_control  = ALU_CTRL_W'(ctrl_q.alu);
  assign bus.Pc_src_mux   = ctrl_q.pc_src;
  assign bus.Imm_zext     = ctrl_q.imm_zext;
  assign bus.state_o      = state_q;
  assign bus.illegal_op   = ctrl_q.illegal;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench: one controller with MEM_WAIT=0, one with MEM_WAIT=2.
module tb_mips_multicycle_ctrl;
  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  mips_multicycle_ctrl_if #(.ALU_CTRL_W(3)) b0 ();
  mips_multicycle_ctrl_if #(.ALU_CTRL_W(3)) b2 ();

  mips_multicycle_ctrl #(.MEM_WAIT(0), .ALU_CTRL_W(3)) u_w0 (.clock(clock), .rst(rst), .bus(b0));
  mips_multicycle_ctrl #(.MEM_WAIT(2), .ALU_CTRL_W(3)) u_w2 (.clock(clock), .rst(rst), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.op = 6'b000010; b0.Funct = 6'b0; b0.Zero = 1'b0;
    b2.op = 6'b000010; b2.Funct = 6'b0; b2.Zero = 1'b0;

    // Reset held for two clocks
    step(); step();
    chk("rst_state",  b0.state_o,   0);
    chk("rst_pcen",   b0.PC_en,     0);
    chk("rst_irw",    b0.IR_write,  0);
    chk("rst_memw",   b0.Mem_write, 0);
    chk("rst_regw",   b0.Reg_write, 0);
    chk("rst_illop",  b0.illegal_op, 0);
    rst = 1'b1; #1;
    chk("fetch_irw",  b0.IR_write,  1);
    chk("fetch_pcen", b0.PC_en,     1);
    chk("fetch_srcb", b0.ALU_srcB_mux, 2'b01);

    // add: 0,1,6,7,0
    b0.op = 6'b000000; b0.Funct = 6'b100000;
    step(); chk("add_s1", b0.state_o, 1); chk("add_dec_srcb", b0.ALU_srcB_mux, 2'b11);
    step(); chk("add_s6", b0.state_o, 6); chk("add_alu", b0.ALU_control, 3'b010);
            chk("add_srca", b0.ALU_srcA_mux, 1); chk("add_exec_regw", b0.Reg_write, 0);
    step(); chk("add_s7", b0.state_o, 7); chk("add_regdst", b0.Reg_Dst_mux, 1);
            chk("add_regw", b0.Reg_write, 1);
    step(); chk("add_s0", b0.state_o, 0); chk("add_after_regw", b0.Reg_write, 0);

    // sub / slt funct decode
    b0.Funct = 6'b100010;
    step(); step(); chk("sub_alu", b0.ALU_control, 3'b110);
    step(); step(); chk("sub_s0", b0.state_o, 0);
    b0.Funct = 6'b101010;
    step(); step(); chk("slt_alu", b0.ALU_control, 3'b111);
    step(); step();

    // ori: 0,1,8,9,0
    b0.op = 6'b001101;
    step(); chk("ori_s1", b0.state_o, 1);
    step(); chk("ori_s8", b0.state_o, 8); chk("ori_alu", b0.ALU_control, 3'b001);
            chk("ori_srcb", b0.ALU_srcB_mux, 2'b10); chk("ori_zext", b0.Imm_zext, 1);
    step(); chk("ori_s9", b0.state_o, 9); chk("ori_regw", b0.Reg_write, 1);
            chk("ori_zext_off", b0.Imm_zext, 0);
    step(); chk("ori_s0", b0.state_o, 0);

    // addi uses add without zero-extension
    b0.op = 6'b001000;
    step(); step(); chk("addi_alu", b0.ALU_control, 3'b010); chk("addi_zext", b0.Imm_zext, 0);
    step(); step();

    // j: 0,1,11,0
    b0.op = 6'b000010;
    step(); chk("j_s1", b0.state_o, 1); chk("j_dec_pcen", b0.PC_en, 0);
    step(); chk("j_s11", b0.state_o, 11); chk("j_pcsrc", b0.Pc_src_mux, 2'b10);
            chk("j_pcen", b0.PC_en, 1);
    step(); chk("j_s0", b0.state_o, 0);

    // beq Zero=1 taken
    b0.op = 6'b000100; b0.Zero = 1'b1;
    step(); step();
    chk("beq_s10", b0.state_o, 10); chk("beq_pcen", b0.PC_en, 1);
    chk("beq_pcsrc", b0.Pc_src_mux, 2'b01); chk("beq_alu", b0.ALU_control, 3'b110);
    step(); chk("beq_s0", b0.state_o, 0);

    // bne with Zero=1 not taken, then Zero=0 taken
    b0.op = 6'b000101;
    step(); step();
    chk("bne_z1_s10", b0.state_o, 10); chk("bne_z1_pcen", b0.PC_en, 0);
    b0.Zero = 1'b0; #1;
    chk("bne_z0_pcen", b0.PC_en, 1);
    step(); chk("bne_s0", b0.state_o, 0);

    // illegal opcode
    b0.op = 6'b111111;
    step(); chk("ill_s1", b0.state_o, 1);
    step();
`ifdef ILLOP_TRAP_EN
    chk("ill_halt", b0.state_o, 15); chk("ill_flag", b0.illegal_op, 1);
    step(); step();
    chk("ill_halt_hold", b0.state_o, 15); chk("ill_flag_hold", b0.illegal_op, 1);
    chk("ill_halt_pcen", b0.PC_en, 0);
    rst = 1'b0;
    step(); chk("ill_rst_s0", b0.state_o, 0); chk("ill_rst_flag", b0.illegal_op, 0);
    rst = 1'b1; #1;
`else
    chk("ill_nop_s0", b0.state_o, 0); chk("ill_nop_flag", b0.illegal_op, 0);
`endif

    // Reset in EXEC of an add: no register write afterwards
    b0.op = 6'b000000; b0.Funct = 6'b100100;
    step(); step();
    chk("mid_s6", b0.state_o, 6); chk("and_alu", b0.ALU_control, 3'b000);
    rst = 1'b0;
    step(); chk("mid_rst_s0", b0.state_o, 0); chk("mid_rst_regw", b0.Reg_write, 0);
    b0.op = 6'b000010;

    // MEM_WAIT=2 instance: restart from a fresh FETCH
    b2.op = 6'b100011;
    rst = 1'b1; #1;
    chk("lw_f0", b2.state_o, 0); chk("lw_f0_irw", b2.IR_write, 0); chk("lw_f0_pcen", b2.PC_en, 0);
    step(); chk("lw_f1", b2.state_o, 0); chk("lw_f1_irw", b2.IR_write, 0);
    step(); chk("lw_f2", b2.state_o, 0); chk("lw_f2_irw", b2.IR_write, 1);
            chk("lw_f2_pcen", b2.PC_en, 1);
    step(); chk("lw_s1", b2.state_o, 1);
    step(); chk("lw_s2", b2.state_o, 2); chk("lw_adr_srcb", b2.ALU_srcB_mux, 2'b10);
    for (int i = 0; i < 3; i++) begin
      step(); chk("lw_memrd", b2.state_o, 3); chk("lw_memrd_lord", b2.lorD_mux, 1);
    end
    step(); chk("lw_s4", b2.state_o, 4); chk("lw_memreg", b2.Mem_reg_mux, 1);
            chk("lw_regw", b2.Reg_write, 1);
    step(); chk("lw_back_s0", b2.state_o, 0);

    b2.op = 6'b101011;
    step(); step();
    chk("sw_f2_irw", b2.IR_write, 1);
    step(); chk("sw_s1", b2.state_o, 1);
    step(); chk("sw_s2", b2.state_o, 2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sw_memwr", b2.state_o, 5);
      chk("sw_lord", b2.lorD_mux, 1);
      chk("sw_memw", b2.Mem_write, (i == 2) ? 1 : 0);
    end
    step(); chk("sw_back_s0", b2.state_o, 0); chk("sw_after_memw", b2.Mem_write, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Parametrised multicycle MIPS control unit. It replaces the per-opcode step-counter controller with a single shared-state Moore FSM (fetch/decode/execute/writeback) plus an internal ALU decoder. It drives the same datapath mux selects and enables, supports lw/sw/R-type/addi/ori/beq/bne/j, and adds configurable memory wait states. It sits between the instruction register (op/Funct) and the multicycle datapath.

Parameters:
MEM_WAIT, 0, extra stall cycles inserted in each memory-access state (FETCH, MEMRD, MEMWR); 0..15.
ALU_CTRL_W, 3, width of ALU_control; must be ≥3; bits above [2:0] are driven 0.

Ports:
clock  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-low
op  in  6  opcode from IR
Funct  in  6  function field from IR
Zero  in  1  ALU zero flag
PC_en  out  1  PC register enable (PC_write | branch-taken)
Mem_write  out  1  RAM write enable
lorD_mux  out  1  address mux: 0 = PC, 1 = ALUOut
IR_write  out  1  instruction register enable
Reg_Dst_mux  out  1  0 = rt, 1 = rd
Mem_reg_mux  out  1  0 = ALUOut, 1 = mem data
Reg_write  out  1  register file write enable
ALU_srcA_mux  out  1  0 = PC, 1 = A
ALU_srcB_mux  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
ALU_control  out  ALU_CTRL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
Pc_src_mux  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
Imm_zext  out  1  1 = zero-extend immediate (ori)
state_o  out  4  current state code (debug)
illegal_op  out  1  illegal-instruction flag

Behaviour:
- Reset: clock and reset are as stated above. On a posedge with rst=0: state←FETCH, wait counter←0. While rst=0, all enables (PC_en, Mem_write, IR_write, Reg_write) are forced 0. Selects take their FETCH values. illegal_op=0.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, IEXEC 8, IWB 9, BRANCH 10, JUMP 11, HALT 15.
- Transitions:
  - FETCH→DECODE.
  - DECODE: op 100011/101011→MEMADR; 000000 with legal Funct→EXEC; 001000/001101→IEXEC; 000100/000101→BRANCH; 000010→JUMP; else illegal.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB→FETCH; MEMWR→FETCH.
  - EXEC→ALUWB→FETCH; IEXEC→IWB→FETCH; BRANCH→FETCH; JUMP→FETCH.
- Outputs (Moore; unlisted outputs are 0):
  - FETCH: IR_write=1, PC_en=1, srcA 0, srcB 01, add.
  - DECODE: srcA 0, srcB 11, add.
  - MEMADR: srcA 1, srcB 10, add.
  - MEMRD: lorD 1.
  - MEMWB: Mem_reg 1, Reg_write 1.
  - MEMWR: lorD 1, Mem_write 1.
  - EXEC: srcA 1, srcB 00, ALU per Funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt).
  - ALUWB: Reg_Dst 1, Reg_write 1.
  - IEXEC: srcA 1, srcB 10; addi→add, ori→or with Imm_zext=1.
  - IWB: Reg_write 1.
  - BRANCH: srcA 1, srcB 00, sub, Pc_src 01; PC_en = Zero (beq) or ~Zero (bne).
  - JUMP: Pc_src 10, PC_en 1.
- Wait states:
  - FETCH, MEMRD and MEMWR each last MEM_WAIT+1 cycles.
  - IR_write, PC_en (FETCH) and Mem_write are asserted only in the final cycle; selects are held for the whole state.
  - The counter clears on every state exit.
- Latency with MEM_WAIT=0: R/addi/ori/sw 4, lw 5, beq/bne/j 3 cycles. Each memory state adds MEM_WAIT.
- Reset asserted mid-instruction: the next posedge returns to FETCH and no partial write completes after that edge.
- op/Funct are sampled only in DECODE/EXEC/IEXEC/BRANCH/MEMADR and are assumed stable from IR.

Optional Feature:
ILLOP_TRAP_EN.
- Defined: an illegal op/Funct in DECODE→HALT. HALT asserts illegal_op=1 with all enables 0 and stays there until reset.
- Undefined: an illegal instruction is treated as a NOP (DECODE→FETCH), and illegal_op is tied 0.

Test Plan:
- Reset: hold rst=0 for 2 clocks → state_o=0, PC_en=Mem_write=Reg_write=IR_write=0; release → FETCH shows IR_write=1, PC_en=1.
- add (op 000000, Funct 100000), MEM_WAIT=0 → states 0,1,6,7,0; ALU_control=010 in EXEC; Reg_Dst=1 and Reg_write=1 for exactly one cycle.
- lw then sw, MEM_WAIT=2 → lw visits 0,1,2,3,4 in 3+1+1+3+1 cycles with Mem_reg=1 in MEMWB; sw asserts Mem_write only in the third MEMWR cycle, with lorD=1 for all three.
- beq with Zero=1 → PC_en=1, Pc_src=01 in BRANCH. bne with Zero=1 → PC_en=0. bne with Zero=0 → PC_en=1.
- ori (001101) → IEXEC shows ALU_control=001, srcB 10, Imm_zext=1. j (000010) → JUMP shows Pc_src=10, PC_en=1, then FETCH.
- op 111111: with ILLOP_TRAP_EN → state_o=15 and illegal_op=1 held until rst=0; without it → state returns to 0 after DECODE.
